// File: rtl/rss_result_tx_pkg.sv
// Shared defaults and helpers for the reservation-station result transmitter.
// The FIFO operation encoding is shared so the buffer's next-state logic reads as one case.
package rss_result_tx_pkg;

    localparam int RESULT_FIFO_DEPTH  = 4;
    localparam int RO_BUFFER_ID_WIDTH = 4;
    localparam int REG_WIDTH          = 32;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Packed entry layout is {dest, value, next_pc}.
    function automatic int result_width(input int rob_id_width, input int xlen);
        return rob_id_width + 2 * xlen;
    endfunction

endpackage

// File: rtl/rss_result_tx_if.sv
// Result-bus interface: RS-station input handshake plus the granted broadcast bus.
// slave is the transmitter's view, master is the environment (RS station + arbiter + consumers).
interface rss_result_tx_if #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int XLEN         = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ROB_ID_WIDTH-1:0] in_dest;
    logic [XLEN-1:0]         in_value;
    logic [XLEN-1:0]         in_next_pc;

    logic                    bus_grant;
    logic                    bus_valid;
    logic [ROB_ID_WIDTH-1:0] bus_dest;
    logic [XLEN-1:0]         bus_value;
    logic [XLEN-1:0]         bus_next_pc;

    modport slave (
        input  in_valid, in_dest, in_value, in_next_pc, bus_grant,
        output in_ready, bus_valid, bus_dest, bus_value, bus_next_pc
    );

    modport master (
        output in_valid, in_dest, in_value, in_next_pc, bus_grant,
        input  in_ready, bus_valid, bus_dest, bus_value, bus_next_pc
    );
endinterface

// File: rtl/rss_result_tx_fifo.sv
// Generic synchronous FIFO with clear; head entry is readable combinationally so a
// freshly written entry is visible the cycle after its push edge.
module rss_result_tx_fifo
    import rss_result_tx_pkg::*;
#(
    parameter int WIDTH = 68,
    parameter int DEPTH = RESULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    fifo_op_e         op;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[head_q];

    // Clear wins over everything; a full FIFO refuses pushes even if it pops this cycle.
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;
    assign op      = fifo_op_e'({pop_ok, push_ok});

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    tail_d  = tail_q + PTR_W'(1);
                    count_d = count_q + CNT_W'(1);
                end
                FIFO_POP: begin
                    head_d  = head_q + PTR_W'(1);
                    count_d = count_q - CNT_W'(1);
                end
                FIFO_BOTH: begin
                    head_d = head_q + PTR_W'(1);
                    tail_d = tail_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: empty entries are never presented on the bus.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= wr_data;
        end
    end

endmodule

// File: rtl/rss_result_tx.sv
// Result-bus transmitter: buffers completed RS results and broadcasts the oldest one
// whenever the arbiter grants; rdy freezes everything, flush discards the buffer.
module rss_result_tx
    import rss_result_tx_pkg::*;
#(
    parameter int DEPTH        = RESULT_FIFO_DEPTH,
    parameter int ROB_ID_WIDTH = RO_BUFFER_ID_WIDTH,
    parameter int XLEN         = REG_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    input  logic           flush,
    rss_result_tx_if.slave bus
);
    localparam int WIDTH = result_width(ROB_ID_WIDTH, XLEN);

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] bus_data;

    assign bus.in_ready  = ~fifo_full;
    assign bus.bus_valid = ~fifo_empty;

    assign fifo_push  = rdy & bus.in_valid & ~fifo_full & ~flush;
    assign fifo_pop   = rdy & ~fifo_empty & bus.bus_grant & ~flush;
    assign fifo_clear = rdy & flush;

    assign wr_data = {bus.in_dest, bus.in_value, bus.in_next_pc};

    // Consumers may latch bus_* regardless of bus_valid, so an empty buffer drives zeros.
    assign bus_data = fifo_empty ? '0 : head_data;

    assign bus.bus_dest    = bus_data[WIDTH-1 -: ROB_ID_WIDTH];
    assign bus.bus_value   = bus_data[2*XLEN-1 -: XLEN];
    assign bus.bus_next_pc = bus_data[XLEN-1:0];

    rss_result_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .wr_data   (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

endmodule
